// File: rtl/hazard_md_unit_pkg.sv
// Shared constants for the Tuse/Tnew hazard unit: default widths and latencies,
// forwarding select encodings and the "operand not used" Tuse value.
package hazard_md_unit_pkg;

  localparam int RA_W_DEF     = 5;
  localparam int T_W_DEF      = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 32;

  // D-stage selects use all four codes; E-stage selects use FWD_ID/FWD_W/FWD_M.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;
  localparam logic [1:0] FWD_ID = 2'd0;

  localparam logic [T_W_DEF-1:0] TUSE_NONE = {T_W_DEF{1'b1}};

endpackage

// File: rtl/hazard_md_unit_md_busy_counter.sv
// Mult/div occupancy counter: loads the operation latency when an MD op leaves E,
// then counts down; busy is registered alongside the count.
module md_busy_counter #(
  parameter int CW       = 4,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT);
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // A new start always reloads, even while busy, so the last start wins.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_md_unit.sv
// Tuse/Tnew hazard unit for the 5-stage MIPS32 pipeline: D/E forwarding selects,
// data and mult/div stalls, and a saturating stall-cycle counter.
module hazard_md_unit
  import hazard_md_unit_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int T_W      = T_W_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs_D,
  input  logic [RA_W-1:0]  rt_D,
  input  logic [T_W-1:0]   tuse_rs_D,
  input  logic [T_W-1:0]   tuse_rt_D,
  input  logic [RA_W-1:0]  rs_E,
  input  logic [RA_W-1:0]  rt_E,
  input  logic [RA_W-1:0]  writereg_E,
  input  logic [RA_W-1:0]  writereg_M,
  input  logic [RA_W-1:0]  writereg_W,
  input  logic             regwrite_E,
  input  logic             regwrite_M,
  input  logic             regwrite_W,
  input  logic [T_W-1:0]   tnew_E,
  input  logic [T_W-1:0]   tnew_M,
  input  logic             md_op_D,
  input  logic             md_start_E,
  input  logic             md_div_E,
  output logic             stall,
  output logic             flush_E,
  output logic             md_busy,
  output logic [1:0]       forward_AD,
  output logic [1:0]       forward_BD,
  output logic [1:0]       forward_AE,
  output logic [1:0]       forward_BE,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MD_CW  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // $0 is hard-wired, so it can never be a real producer.
  function automatic logic stage_match(input logic rw, input logic [RA_W-1:0] wr,
                                       input logic [RA_W-1:0] src);
    return rw && (wr == src) && (src != '0);
  endfunction

  // A matching stage whose result is not ready yet blocks older producers.
  function automatic logic [1:0] fwd_sel_d(input logic [RA_W-1:0] src);
    logic [1:0] sel;
    if (stage_match(regwrite_E, writereg_E, src)) begin
      sel = (tnew_E == '0) ? FWD_E : FWD_RF;
    end else if (stage_match(regwrite_M, writereg_M, src)) begin
      sel = (tnew_M == '0) ? FWD_M : FWD_RF;
    end else if (stage_match(regwrite_W, writereg_W, src)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [RA_W-1:0] src);
    logic [1:0] sel;
    if (stage_match(regwrite_M, writereg_M, src) && (tnew_M == '0)) begin
      sel = FWD_M;
    end else if (stage_match(regwrite_W, writereg_W, src)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_ID;
    end
    return sel;
  endfunction

  function automatic logic data_stall(input logic [RA_W-1:0] src, input logic [T_W-1:0] tuse);
    return (stage_match(regwrite_E, writereg_E, src) && (tnew_E > tuse)) ||
           (stage_match(regwrite_M, writereg_M, src) && (tnew_M > tuse));
  endfunction

  logic stall_rs_s, stall_rt_s, stall_md_s, stall_s;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  md_busy_counter #(
    .CW       (MD_CW),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start_E),
    .div_i   (md_div_E),
    .busy_o  (md_busy)
  );

  always_comb begin
    stall_rs_s = data_stall(rs_D, tuse_rs_D);
    stall_rt_s = data_stall(rt_D, tuse_rt_D);
    stall_md_s = md_op_D && (md_busy || md_start_E);
    stall_s    = stall_rs_s || stall_rt_s || stall_md_s;
    forward_AD = fwd_sel_d(rs_D);
    forward_BD = fwd_sel_d(rt_D);
    forward_AE = fwd_sel_e(rs_E);
    forward_BE = fwd_sel_e(rt_E);
  end

  assign stall   = stall_s;
  assign flush_E = stall_s;

  always_comb begin
    if (stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_md_unit.sv
// Scoreboard bench for hazard_md_unit: directed scenarios plus random traffic,
// with a second instance at CNT_W=3 to exercise counter saturation.
module tb_hazard_md_unit;

  typedef struct {
    logic [4:0] rs_D, rt_D, rs_E, rt_E, wE, wM, wW;
    logic [1:0] tuse_rs, tuse_rt, tnE, tnM;
    logic       rwE, rwM, rwW, md_op, md_start, md_div;
  } stim_t;

  typedef struct {
    logic        stall;
    logic [1:0]  fad, fbd, fae, fbe;
    logic        busy;
    logic [31:0] sc;
    logic [2:0]  scs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic regwrite_E, regwrite_M, regwrite_W, md_op_D, md_start_E, md_div_E;
  logic stall, flush_E, md_busy, stall_s3, flush_s3, busy_s3;
  logic [1:0] forward_AD, forward_BD, forward_AE, forward_BE;
  logic [1:0] fad3, fbd3, fae3, fbe3;
  logic [31:0] stall_cycles;
  logic [2:0] stall_cycles3;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  // reference state: busy through cycle busy_until; counts of stalled edges
  int cyc = 0;
  int busy_until = -1;
  int sc_big = 0;
  int sc_small = 0;

  always #5 clk = ~clk;

  hazard_md_unit u_dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D),
    .tuse_rt_D(tuse_rt_D), .rs_E(rs_E), .rt_E(rt_E), .writereg_E(writereg_E),
    .writereg_M(writereg_M), .writereg_W(writereg_W), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_op_D(md_op_D), .md_start_E(md_start_E), .md_div_E(md_div_E), .stall(stall),
    .flush_E(flush_E), .md_busy(md_busy), .forward_AD(forward_AD), .forward_BD(forward_BD),
    .forward_AE(forward_AE), .forward_BE(forward_BE), .stall_cycles(stall_cycles)
  );

  hazard_md_unit #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D),
    .tuse_rt_D(tuse_rt_D), .rs_E(rs_E), .rt_E(rt_E), .writereg_E(writereg_E),
    .writereg_M(writereg_M), .writereg_W(writereg_W), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_op_D(md_op_D), .md_start_E(md_start_E), .md_div_E(md_div_E), .stall(stall_s3),
    .flush_E(flush_s3), .md_busy(busy_s3), .forward_AD(fad3), .forward_BD(fbd3),
    .forward_AE(fae3), .forward_BE(fbe3), .stall_cycles(stall_cycles3)
  );

  function automatic bit m(input logic rw, input logic [4:0] w, input logic [4:0] src);
    return rw && (w == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] ref_fd(input stim_t s, input logic [4:0] src);
    if (m(s.rwE, s.wE, src)) return (s.tnE == 2'd0) ? 2'd3 : 2'd0;
    if (m(s.rwM, s.wM, src)) return (s.tnM == 2'd0) ? 2'd2 : 2'd0;
    if (m(s.rwW, s.wW, src)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] ref_fe(input stim_t s, input logic [4:0] src);
    if (m(s.rwM, s.wM, src) && s.tnM == 2'd0) return 2'd2;
    if (m(s.rwW, s.wW, src)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit ref_ds(input stim_t s, input logic [4:0] src, input logic [1:0] tuse);
    return (m(s.rwE, s.wE, src) && s.tnE > tuse) || (m(s.rwM, s.wM, src) && s.tnM > tuse);
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.rs_D = 5'd0; s.rt_D = 5'd0; s.rs_E = 5'd0; s.rt_E = 5'd0;
    s.wE = 5'd0; s.wM = 5'd0; s.wW = 5'd0;
    s.tuse_rs = 2'd0; s.tuse_rt = 2'd0; s.tnE = 2'd0; s.tnM = 2'd0;
    s.rwE = 1'b0; s.rwM = 1'b0; s.rwW = 1'b0;
    s.md_op = 1'b0; s.md_start = 1'b0; s.md_div = 1'b0;
    return s;
  endfunction

  // Apply one cycle of stimulus mid-cycle and queue what the outputs must be.
  task automatic drive(input stim_t s, input bit rst);
    exp_t e;
    bit busy;
    @(posedge clk);
    #1;
    rs_D = s.rs_D; rt_D = s.rt_D; rs_E = s.rs_E; rt_E = s.rt_E;
    writereg_E = s.wE; writereg_M = s.wM; writereg_W = s.wW;
    tuse_rs_D = s.tuse_rs; tuse_rt_D = s.tuse_rt; tnew_E = s.tnE; tnew_M = s.tnM;
    regwrite_E = s.rwE; regwrite_M = s.rwM; regwrite_W = s.rwW;
    md_op_D = s.md_op; md_start_E = s.md_start; md_div_E = s.md_div;
    reset = rst;
    if (rst) begin
      busy_until = -1;
      sc_big = 0;
      sc_small = 0;
    end
    busy = (cyc <= busy_until);
    e.stall = ref_ds(s, s.rs_D, s.tuse_rs) || ref_ds(s, s.rt_D, s.tuse_rt) ||
              (s.md_op && (busy || s.md_start));
    e.fad = ref_fd(s, s.rs_D);
    e.fbd = ref_fd(s, s.rt_D);
    e.fae = ref_fe(s, s.rs_E);
    e.fbe = ref_fe(s, s.rt_E);
    e.busy = busy;
    e.sc = 32'(sc_big);
    e.scs = 3'(sc_small);
    exp_q.push_back(e);
    if (!rst) begin
      if (e.stall) begin
        sc_big++;
        if (sc_small < 7) sc_small++;
      end
      if (s.md_start) busy_until = cyc + (s.md_div ? 10 : 5);
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cycle-time %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: every queued expectation is checked against the DUT mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", {31'd0, stall}, {31'd0, e.stall});
      chk("flush_E", {31'd0, flush_E}, {31'd0, e.stall});
      chk("forward_AD", {30'd0, forward_AD}, {30'd0, e.fad});
      chk("forward_BD", {30'd0, forward_BD}, {30'd0, e.fbd});
      chk("forward_AE", {30'd0, forward_AE}, {30'd0, e.fae});
      chk("forward_BE", {30'd0, forward_BE}, {30'd0, e.fbe});
      chk("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
      chk("stall_cycles", stall_cycles, e.sc);
      chk("stall_cycles_sat", {29'd0, stall_cycles3}, {29'd0, e.scs});
      chk("md_busy_sat", {31'd0, busy_s3}, {31'd0, e.busy});
    end
  end

  initial begin
    stim_t s;
    int waited;
    s = zero_stim();
    rs_D = 5'd0; rt_D = 5'd0; rs_E = 5'd0; rt_E = 5'd0;
    writereg_E = 5'd0; writereg_M = 5'd0; writereg_W = 5'd0;
    tuse_rs_D = 2'd0; tuse_rt_D = 2'd0; tnew_E = 2'd0; tnew_M = 2'd0;
    regwrite_E = 1'b0; regwrite_M = 1'b0; regwrite_W = 1'b0;
    md_op_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;
    #2 reset = 1'b1;

    // reset idle
    drive(s, 1'b1);
    drive(s, 1'b1);
    drive(s, 1'b0);

    // load-use, then ready E result forwarded
    s.wE = 5'd8; s.rwE = 1'b1; s.tnE = 2'd2; s.rs_D = 5'd8; s.tuse_rs = 2'd1; s.tuse_rt = 2'd3;
    drive(s, 1'b0);
    s.tnE = 2'd0;
    drive(s, 1'b0);

    // E-stage priority M > W, then $0
    s = zero_stim();
    s.wM = 5'd9; s.wW = 5'd9; s.rwM = 1'b1; s.rwW = 1'b1; s.rs_E = 5'd9; s.rt_E = 5'd9;
    drive(s, 1'b0);
    s.rwM = 1'b0;
    drive(s, 1'b0);
    s.rs_E = 5'd0; s.rt_E = 5'd0; s.wM = 5'd0; s.wW = 5'd0; s.rwM = 1'b1;
    drive(s, 1'b0);

    // mult busy window with an MD-dependent instruction waiting in D
    s = zero_stim();
    drive(s, 1'b1);
    s.md_op = 1'b1; s.md_start = 1'b1;
    drive(s, 1'b0);
    s.md_start = 1'b0;
    for (int i = 0; i < 7; i++) drive(s, 1'b0);

    // division interrupted by reset mid-flight
    s.md_start = 1'b1; s.md_div = 1'b1;
    drive(s, 1'b0);
    s.md_start = 1'b0; s.md_div = 1'b0;
    for (int i = 0; i < 3; i++) drive(s, 1'b0);
    drive(s, 1'b1);
    drive(s, 1'b0);

    // long data stall to saturate the narrow counter
    s = zero_stim();
    s.wM = 5'd4; s.rwM = 1'b1; s.tnM = 2'd2; s.rt_D = 5'd4; s.tuse_rt = 2'd0;
    for (int i = 0; i < 10; i++) drive(s, 1'b0);

    // random traffic on a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      s.rs_D = 5'($urandom_range(0, 3)); s.rt_D = 5'($urandom_range(0, 3));
      s.rs_E = 5'($urandom_range(0, 3)); s.rt_E = 5'($urandom_range(0, 3));
      s.wE = 5'($urandom_range(0, 3)); s.wM = 5'($urandom_range(0, 3));
      s.wW = 5'($urandom_range(0, 3));
      s.tuse_rs = 2'($urandom_range(0, 3)); s.tuse_rt = 2'($urandom_range(0, 3));
      s.tnE = 2'($urandom_range(0, 3)); s.tnM = 2'($urandom_range(0, 3));
      s.rwE = 1'($urandom_range(0, 1)); s.rwM = 1'($urandom_range(0, 1));
      s.rwW = 1'($urandom_range(0, 1));
      s.md_op = 1'($urandom_range(0, 1));
      s.md_start = ($urandom_range(0, 9) == 0);
      s.md_div = 1'($urandom_range(0, 1));
      drive(s, ($urandom_range(0, 99) == 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
